// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared state encoding and index-width helper for the dff write arbiter
package dff_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first request at or after ptr with wrap-around
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any_req,
  output logic [IW-1:0] idx
);
  assign any_req = |req;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin arbiter loading one shared register from N_REQ valid/ready requesters
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         q,
  output logic                     q_upd,
  output logic [idx_w(N_REQ)-1:0]  q_src,
  output logic                     busy,
  output logic [CNT_W-1:0]         wr_count
);
  localparam int IW = idx_w(N_REQ);
  state_t            state_q, state_d;
  logic [IW-1:0]     g_q, g_d, ptr_q, ptr_d, src_q, src_d, pick;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              upd_q, upd_d, any_req, wr;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .any_req(any_req),
    .idx    (pick)
  );
  always_comb begin
    wr      = state_q == GRANT && req_valid[g_q];
    state_d = (state_q == IDLE && any_req) ? GRANT : IDLE;
    g_d     = (state_q == IDLE) ? pick : g_q;
    ptr_d   = wr ? ((g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1) : ptr_q;
    q_d     = wr ? req_data[g_q*WIDTH +: WIDTH] : q_q;
    src_d   = wr ? g_q : src_q;
    upd_d   = wr;
    cnt_d   = (wr && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      src_q   <= '0;
      q_q     <= '0;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      q_q     <= q_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
    end
  end
  assign req_ready = (state_q == GRANT) ? (N_REQ'(1) << g_q) : '0;
  assign busy      = state_q == GRANT;
  assign q         = q_q;
  assign q_upd     = upd_q;
  assign q_src     = src_q;
  assign wr_count  = cnt_q;
endmodule
